frame_pixel_writer: RTL and testbench

- Sits directly downstream of the draw controller and upstream of the VGA adapter write port.
- Buffers pixel writes (x, y, color) from the sprite drawers in a small FIFO and drains them to the adapter at one pixel per cycle.
- On each frame_start it first drains pending pixels, then sweeps the whole screen with the background color, then resumes draining new-frame pixels.
- Reports clear completion and frame overruns to the game loop.

---
 rtl/asteroids_pkg.sv | 16 +
 rtl/pixel_fifo.sv | 51 +++++
 rtl/frame_pixel_writer.sv | 154 +++++++++++++++
 tb/tb_frame_pixel_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared types and defaults for the frame pixel writer and its FIFO.
package asteroids_pkg;
  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int COLOR_W   = 3;
  localparam int COORD_W   = 10;
  localparam logic [COLOR_W-1:0] BG_COLOR_DEF = 3'b000;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} wr_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO of pixel_t; dout is the head entry whenever !empty.
module pixel_fifo
  import asteroids_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output pixel_t dout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  pixel_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/frame_pixel_writer.sv
// Buffers sprite pixel writes and drains them to the VGA adapter; on frame_start
// it finishes old-frame pixels, sweeps the screen with BG_COLOR, then resumes.
// Optional macro FRAME_WRITER_CLIP_EN discards off-screen pixels and counts them.
// Note: reset_n is active-high despite its name.
module frame_pixel_writer
  import asteroids_pkg::*;
#(
  parameter int                 H_RES      = H_RES_DEF,
  parameter int                 V_RES      = V_RES_DEF,
  parameter int                 FIFO_DEPTH = 16,
  parameter logic [COLOR_W-1:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_plot,
  output logic               in_ready,
  input  logic               frame_start,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_plot,
  output logic               clear_done,
  output logic               busy,
  output logic               frame_overrun
`ifdef FRAME_WRITER_CLIP_EN
  ,
  output logic [7:0]         clip_count
`endif
);
  wr_state_t          state_q, state_d;
  logic               fifo_full, fifo_empty, push, pop, drop;
  logic               rdy_q, clear_pending, clear_last;
  logic [COORD_W-1:0] cx, cy;
  pixel_t             fifo_din, fifo_dout;

  assign fifo_din = '{x: in_x, y: in_y, color: in_color};
  // rdy_q keeps in_ready low while reset is held and for the release cycle.
  assign in_ready = rdy_q && !fifo_full;
  assign push     = in_plot && in_ready;
  assign busy     = (state_q != IDLE) || !fifo_empty;

`ifdef FRAME_WRITER_CLIP_EN
  assign drop = (fifo_dout.x >= COORD_W'(H_RES)) || (fifo_dout.y >= COORD_W'(V_RES));
`else
  assign drop = 1'b0;
`endif

  pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (fifo_dout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: queued pixels always go before a pending clear; pops start straight from IDLE.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    clear_last = 1'b0;
    case (state_q)
      IDLE, DRAIN: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRAIN;
        end else if (clear_pending) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clear_last = (cx == COORD_W'(H_RES - 1)) && (cy == COORD_W'(V_RES - 1));
        if (clear_last) state_d = fifo_empty ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep counters; they finish back at (0,0) ready for the next clear.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (state_q == CLEAR) begin
      if (cx == COORD_W'(H_RES - 1)) begin
        cx <= '0;
        cy <= (cy == COORD_W'(V_RES - 1)) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Frame request bookkeeping: one pending clear at most, extras flag an overrun.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      clear_pending <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      if (state_q == CLEAR)                  clear_pending <= 1'b0;
      else if (frame_start && !clear_pending) clear_pending <= 1'b1;
      if (frame_start && (state_q == CLEAR || clear_pending)) frame_overrun <= 1'b1;
    end
  end

  // Adapter write port; coordinates hold their last value when idle.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rdy_q      <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_color  <= '0;
      out_plot   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      out_plot   <= 1'b0;
      clear_done <= 1'b0;
      if (state_q == CLEAR) begin
        out_x      <= cx;
        out_y      <= cy;
        out_color  <= BG_COLOR;
        out_plot   <= 1'b1;
        clear_done <= clear_last;
      end else if (pop && !drop) begin
        out_x     <= fifo_dout.x;
        out_y     <= fifo_dout.y;
        out_color <= fifo_dout.color;
        out_plot  <= 1'b1;
      end
    end
  end

`ifdef FRAME_WRITER_CLIP_EN
  // Saturating count of discarded off-screen pixels.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                           clip_count <= '0;
    else if (pop && drop && clip_count != 8'hFF) clip_count <= clip_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_frame_pixel_writer.sv
// Self-checking bench: a queue of expected adapter writes is built from the
// drawing rules (pixels in push order, full-screen sweeps) and every write is
// checked against it by a monitor; scenario tasks add targeted checks.
module tb_frame_pixel_writer;
  import asteroids_pkg::*;

  localparam int H = 160;
  localparam int V = 120;

  typedef struct {
    int x;
    int y;
    int c;
    bit last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [9:0]   in_x = '0, in_y = '0;
  logic [2:0]   in_color = '0;
  logic         in_plot = 1'b0, frame_start = 1'b0;
  logic         in_ready, out_plot, clear_done, busy, frame_overrun;
  logic [9:0]   out_x, out_y;
  logic [2:0]   out_color;
`ifdef FRAME_WRITER_CLIP_EN
  logic [7:0]   clip_count;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cd_count = 0;
  bit   mon_en = 1'b0;
  bit   prev_cd = 1'b0;

  frame_pixel_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_color      (in_color),
    .in_plot       (in_plot),
    .in_ready      (in_ready),
    .frame_start   (frame_start),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_color     (out_color),
    .out_plot      (out_plot),
    .clear_done    (clear_done),
    .busy          (busy),
    .frame_overrun (frame_overrun)
`ifdef FRAME_WRITER_CLIP_EN
    ,
    .clip_count    (clip_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every adapter write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && !reset_n) begin
      if (out_plot) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_plot: got (%0d,%0d,%0d) with nothing expected", out_x, out_y, out_color);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_x !== 10'(mon_e.x) || out_y !== 10'(mon_e.y) || out_color !== 3'(mon_e.c)
              || clear_done !== mon_e.last) begin
            n_fail++;
            $display("FAIL plot_data: got (%0d,%0d,%0d,cd=%0b) want (%0d,%0d,%0d,cd=%0b)",
                     out_x, out_y, out_color, clear_done, mon_e.x, mon_e.y, mon_e.c, mon_e.last);
          end
        end
      end else begin
        if (clear_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL clear_done_no_plot: clear_done=1 with out_plot=0");
        end
        if (prev_cd && exp_q.size() > 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL held_after_clear: out_plot=0 right after clear_done, want 1");
        end
      end
      if (clear_done) cd_count++;
      prev_cd = clear_done;
    end
  end

  // Present one pixel (caller sits at a negedge); waits for in_ready, bounded.
  task automatic do_push(input int x, input int y, input int c, input bit fs, input bit expect_out);
    int guard = 0;
    in_x = 10'(x); in_y = 10'(y); in_color = 3'(c); in_plot = 1'b1;
    while (!in_ready && guard < 25000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: in_ready=0 after %0d cycles, want 1", guard);
    end else if (expect_out) begin
      exp_q.push_back('{x, y, c, 1'b0});
    end
    frame_start = fs;
    @(negedge clk);
    in_plot = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic expect_clear();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back('{x, y, int'(BG_COLOR_DEF), (x == H-1 && y == V-1)});
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 25000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: pending=%0d busy=%0b, want 0 and 0", tag, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || frame_overrun !== 1'b0 || clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: plot=%0b busy=%0b rdy=%0b ovr=%0b cd=%0b, want all 0",
               out_plot, busy, in_ready, frame_overrun, clear_done);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: plot=%0b busy=%0b rdy=%0b ovr=%0b, want 0 0 1 0",
               out_plot, busy, in_ready, frame_overrun);
    end
  endtask

  task automatic test_latency();
    in_x = 10'd5; in_y = 10'd7; in_color = 3'b110; in_plot = 1'b1;
    exp_q.push_back('{5, 7, 6, 1'b0});
    @(negedge clk);
    in_plot = 1'b0;
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_n1: plot=%0b busy=%0b, want 0 1", out_plot, busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_plot !== 1'b1 || out_x !== 10'd5 || out_y !== 10'd7 || out_color !== 3'b110) begin
      n_fail++;
      $display("FAIL latency_n2: got plot=%0b (%0d,%0d,%0d) want 1 (5,7,6)", out_plot, out_x, out_y, out_color);
    end
    wait_idle("latency");
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 30; i++) begin
      do_push(int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("stream");
  endtask

  // Three old-frame pixels, frame_start coincident with the third push.
  task automatic test_frame_clear();
    for (int i = 0; i < 3; i++)
      do_push(int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)), int'($urandom_range(1, 7)), i == 2, 1'b1);
    expect_clear();
    repeat (10) @(negedge clk);
    n_checks++;
    if (frame_overrun !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_accept: ovr=%0b busy=%0b, want 0 1", frame_overrun, busy);
    end
  endtask

  // Runs while the sweep is in progress: fill the FIFO, overflow it, and drop a frame_start.
  task automatic test_back_to_back(input int cd_base);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready: in_ready=%0b after %0d accepted, want 1", in_ready, i);
      end
      do_push(int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: in_ready=%0b after 16 accepted, want 0", in_ready);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n_checks++;
    if (frame_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: frame_overrun=%0b, want 1", frame_overrun);
    end
    for (int i = 0; i < 4; i++)
      do_push(int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
    wait_idle("b2b");
    repeat (5) @(negedge clk);
    n_checks++;
    if (cd_count - cd_base !== 1 || frame_overrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL one_sweep: clear_done pulses=%0d ovr=%0b busy=%0b, want 1 1 0",
               cd_count - cd_base, frame_overrun, busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard = 0;
    mon_en = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    while (!(out_plot && out_x == 10'd40 && out_y == 10'd2) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL sweep_reach: write (40,2) not seen in 2000 cycles, want seen");
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0 || frame_overrun !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: plot=%0b busy=%0b cd=%0b ovr=%0b rdy=%0b, want all 0",
               out_plot, busy, clear_done, frame_overrun, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (clear_done !== 1'b0 || out_plot !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: cd=%0b plot=%0b busy=%0b, want 0 0 0", clear_done, out_plot, busy);
      end
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: in_ready=%0b, want 1", in_ready);
    end
    exp_q.delete();
    prev_cd = 1'b0;
    mon_en = 1'b1;
  endtask

`ifdef FRAME_WRITER_CLIP_EN
  task automatic test_clip();
    do_push(200, 10, 5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (clip_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clip: clip_count=%0d busy=%0b, want 1 0", clip_count, busy);
    end
  endtask
`endif

  initial begin
    int cd_base;
    test_reset();
    mon_en = 1'b1;
    test_latency();
    test_random_stream();
    cd_base = cd_count;
    test_frame_clear();
    test_back_to_back(cd_base);
    test_reset_mid_clear();
    test_latency();
`ifdef FRAME_WRITER_CLIP_EN
    test_clip();
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
